// File: rtl/sc_fifo_ram.sv
// Simple dual-port storage for sc_fifo: one write port, one enabled read port.
// Read data is registered (one-cycle latency); REGISTER_OUTPUT adds a second stage.
module sc_ram #(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 10,
  parameter bit REGISTER_OUTPUT = 1'b0
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [DWIDTH-1:0] q_o
);

  logic [DWIDTH-1:0] r_mem [2**AWIDTH];
  logic [DWIDTH-1:0] r_rd_data;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
  end

  generate
    if (REGISTER_OUTPUT) begin : g_out_reg
      logic [DWIDTH-1:0] r_q;
      always_ff @(posedge clk_i) r_q <= r_rd_data;
      assign q_o = r_q;
    end else begin : g_out_direct
      assign q_o = r_rd_data;
    end
  endgenerate

endmodule

// File: rtl/sc_fifo.sv
// Single-clock show-ahead FIFO. The RAM read register doubles as the output slot;
// r_valid marks it occupied and a prefetch refills it whenever it empties or is popped.
module sc_fifo #(
  parameter int DWIDTH = 64,
  parameter int AWIDTH = 10
) (
  input  logic              clk_i,
  input  logic              srst_ni,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o
);

  localparam int              DEPTH     = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic              r_valid;
  logic              r_full;
  logic [AWIDTH:0]   r_usedw;

  logic              w_wr;
  logic              w_pop;
  logic              w_has_unread;
  logic              w_prefetch;
  logic [AWIDTH:0]   w_usedw_nxt;
  logic              w_valid_nxt;

  assign w_wr  = wrreq_i & ~r_full;
  assign w_pop = rdreq_i & r_valid;
  // usedw counts the output slot too, so RAM holds unread words when it exceeds r_valid.
  assign w_has_unread = r_usedw > {{AWIDTH{1'b0}}, r_valid};
  assign w_prefetch   = w_has_unread & (~r_valid | w_pop);

  always_comb begin
    w_usedw_nxt = r_usedw;
    if (w_wr && !w_pop)      w_usedw_nxt = r_usedw + (AWIDTH+1)'(1);
    else if (w_pop && !w_wr) w_usedw_nxt = r_usedw - (AWIDTH+1)'(1);

    w_valid_nxt = r_valid;
    if (w_prefetch)  w_valid_nxt = 1'b1;
    else if (w_pop)  w_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_usedw  <= '0;
    end else begin
      if (w_wr)       r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      if (w_prefetch) r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
      r_valid <= w_valid_nxt;
      r_usedw <= w_usedw_nxt;
      r_full  <= (w_usedw_nxt == DEPTH_CNT);
    end
  end

  sc_ram #(
    .DWIDTH         (DWIDTH),
    .AWIDTH         (AWIDTH),
    .REGISTER_OUTPUT(1'b0)
  ) u_ram (
    .clk_i    (clk_i),
    .wr_en_i  (w_wr),
    .wr_addr_i(r_wr_ptr),
    .wr_data_i(data_i),
    .rd_en_i  (w_prefetch),
    .rd_addr_i(r_rd_ptr),
    .q_o      (q_o)
  );

  assign empty_o = ~r_valid;
  assign full_o  = r_full;
  assign usedw_o = r_usedw;

endmodule

// File: tb/tb_sc_fifo.sv
// Directed bench for sc_fifo at DWIDTH=8, AWIDTH=2 (DEPTH=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_sc_fifo;

  logic       clk_i;
  logic       srst_ni;
  logic [7:0] data_i;
  logic       wrreq_i;
  logic       rdreq_i;
  logic [7:0] q_o;
  logic       empty_o;
  logic       full_o;
  logic [2:0] usedw_o;

  int n_checks = 0;
  int n_errors = 0;

  sc_fifo #(.DWIDTH(8), .AWIDTH(2)) dut (
    .clk_i  (clk_i),
    .srst_ni(srst_ni),
    .data_i (data_i),
    .wrreq_i(wrreq_i),
    .rdreq_i(rdreq_i),
    .q_o    (q_o),
    .empty_o(empty_o),
    .full_o (full_o),
    .usedw_o(usedw_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  task automatic test_reset;
    srst_ni = 1'b0; wrreq_i = 1'b1; rdreq_i = 1'b1; data_i = 8'hEE;
    cyc(2);
    if (empty_o !== 1'b1) begin $display("FAIL reset_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
    if (full_o !== 1'b0) begin $display("FAIL reset_full: got %b expected 0", full_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd0) begin $display("FAIL reset_usedw: got %0d expected 0", usedw_o); n_errors++; end n_checks++;
    srst_ni = 1'b1; wrreq_i = 1'b0; rdreq_i = 1'b0;
    cyc(1);
  endtask

  task automatic test_first_write;
    data_i = 8'h11; wrreq_i = 1'b1;
    cyc(1);
    wrreq_i = 1'b0;
    if (usedw_o !== 3'd1) begin $display("FAIL first_usedw: got %0d expected 1", usedw_o); n_errors++; end n_checks++;
    if (empty_o !== 1'b1) begin $display("FAIL first_empty_n: got %b expected 1", empty_o); n_errors++; end n_checks++;
    cyc(1);
    if (empty_o !== 1'b0) begin $display("FAIL first_empty_n1: got %b expected 0", empty_o); n_errors++; end n_checks++;
    if (q_o !== 8'h11) begin $display("FAIL first_q: got %h expected 11", q_o); n_errors++; end n_checks++;
    rdreq_i = 1'b1;
    cyc(1);
    rdreq_i = 1'b0;
    if (empty_o !== 1'b1) begin $display("FAIL first_pop_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd0) begin $display("FAIL first_pop_usedw: got %0d expected 0", usedw_o); n_errors++; end n_checks++;
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 4; i++) begin
      data_i = 8'(i); wrreq_i = 1'b1;
      cyc(1);
    end
    wrreq_i = 1'b0;
    if (full_o !== 1'b1) begin $display("FAIL fill_full: got %b expected 1", full_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd4) begin $display("FAIL fill_usedw: got %0d expected 4", usedw_o); n_errors++; end n_checks++;
    data_i = 8'h05; wrreq_i = 1'b1;
    cyc(1);
    wrreq_i = 1'b0;
    if (usedw_o !== 3'd4) begin $display("FAIL overflow_usedw: got %0d expected 4", usedw_o); n_errors++; end n_checks++;
    if (full_o !== 1'b1) begin $display("FAIL overflow_full: got %b expected 1", full_o); n_errors++; end n_checks++;
    rdreq_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      if (empty_o !== 1'b0) begin $display("FAIL drain_empty[%0d]: got %b expected 0", i, empty_o); n_errors++; end n_checks++;
      if (q_o !== 8'(i)) begin $display("FAIL drain_q[%0d]: got %h expected %h", i, q_o, 8'(i)); n_errors++; end n_checks++;
      cyc(1);
    end
    rdreq_i = 1'b0;
    if (empty_o !== 1'b1) begin $display("FAIL drain_done_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd0) begin $display("FAIL drain_done_usedw: got %0d expected 0", usedw_o); n_errors++; end n_checks++;
  endtask

  task automatic test_full_rw;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'hA0 + 8'(i); wrreq_i = 1'b1;
      cyc(1);
    end
    wrreq_i = 1'b0;
    cyc(1);
    data_i = 8'hFF; wrreq_i = 1'b1; rdreq_i = 1'b1;
    cyc(1);
    wrreq_i = 1'b0; rdreq_i = 1'b0;
    if (usedw_o !== 3'd3) begin $display("FAIL fullrw_usedw: got %0d expected 3", usedw_o); n_errors++; end n_checks++;
    if (full_o !== 1'b0) begin $display("FAIL fullrw_full: got %b expected 0", full_o); n_errors++; end n_checks++;
    rdreq_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (q_o !== 8'hA0 + 8'(i)) begin $display("FAIL fullrw_q[%0d]: got %h expected %h", i, q_o, 8'hA0 + 8'(i)); n_errors++; end n_checks++;
      cyc(1);
    end
    rdreq_i = 1'b0;
    if (empty_o !== 1'b1) begin $display("FAIL fullrw_drained: got %b expected 1", empty_o); n_errors++; end n_checks++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    data_i = 8'hB1; wrreq_i = 1'b1; exp_q.push_back(8'hB1);
    cyc(1);
    data_i = 8'hB2; exp_q.push_back(8'hB2);
    cyc(1);
    wrreq_i = 1'b0;
    cyc(1);
    if (usedw_o !== 3'd2) begin $display("FAIL b2b_start_usedw: got %0d expected 2", usedw_o); n_errors++; end n_checks++;
    // First pass writes 0xAA, then 10 more write/pop cycles wrap both pointers.
    for (int i = 0; i < 11; i++) begin
      data_i = (i == 0) ? 8'hAA : 8'hC0 + 8'(i - 1);
      exp_q.push_back(data_i);
      wrreq_i = 1'b1; rdreq_i = 1'b1;
      if (q_o !== exp_q[0]) begin $display("FAIL b2b_q[%0d]: got %h expected %h", i, q_o, exp_q[0]); n_errors++; end n_checks++;
      void'(exp_q.pop_front());
      cyc(1);
      if (usedw_o !== 3'd2) begin $display("FAIL b2b_usedw[%0d]: got %0d expected 2", i, usedw_o); n_errors++; end n_checks++;
    end
    wrreq_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (q_o !== exp_q[0]) begin $display("FAIL b2b_tail_q[%0d]: got %h expected %h", i, q_o, exp_q[0]); n_errors++; end n_checks++;
      void'(exp_q.pop_front());
      cyc(1);
    end
    rdreq_i = 1'b0;
    if (empty_o !== 1'b1) begin $display("FAIL b2b_end_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
  endtask

  task automatic test_empty_read_and_reset;
    rdreq_i = 1'b1;
    cyc(2);
    rdreq_i = 1'b0;
    if (usedw_o !== 3'd0) begin $display("FAIL empty_rd_usedw: got %0d expected 0", usedw_o); n_errors++; end n_checks++;
    if (empty_o !== 1'b1) begin $display("FAIL empty_rd_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'h30 + 8'(i); wrreq_i = 1'b1;
      cyc(1);
    end
    wrreq_i = 1'b0;
    if (usedw_o !== 3'd3) begin $display("FAIL prerst_usedw: got %0d expected 3", usedw_o); n_errors++; end n_checks++;
    srst_ni = 1'b0; wrreq_i = 1'b1; rdreq_i = 1'b1; data_i = 8'h77;
    cyc(1);
    srst_ni = 1'b1; wrreq_i = 1'b0; rdreq_i = 1'b0;
    if (empty_o !== 1'b1) begin $display("FAIL rst_mid_empty: got %b expected 1", empty_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd0) begin $display("FAIL rst_mid_usedw: got %0d expected 0", usedw_o); n_errors++; end n_checks++;
    if (full_o !== 1'b0) begin $display("FAIL rst_mid_full: got %b expected 0", full_o); n_errors++; end n_checks++;
    data_i = 8'h5A; wrreq_i = 1'b1;
    cyc(1);
    wrreq_i = 1'b0;
    cyc(1);
    if (q_o !== 8'h5A) begin $display("FAIL rst_readback_q: got %h expected 5a", q_o); n_errors++; end n_checks++;
    if (usedw_o !== 3'd1) begin $display("FAIL rst_readback_usedw: got %0d expected 1", usedw_o); n_errors++; end n_checks++;
  endtask

  initial begin
    srst_ni = 1'b0; wrreq_i = 1'b0; rdreq_i = 1'b0; data_i = '0;
    cyc(1);
    test_reset();
    test_first_write();
    test_fill_drain();
    test_full_rw();
    test_back_to_back();
    test_empty_read_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_fifo.md
SC_FIFO -- requirements
Module: sc_fifo

Interface
REQ-001 SHALL have parameter DWIDTH, default 64: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 10: storage address width; capacity DEPTH = 2**AWIDTH words.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port srst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port data_i  input  DWIDTH  write data.
REQ-006 SHALL have port wrreq_i  input  1  write request.
REQ-007 SHALL have port rdreq_i  input  1  read (pop) request; acknowledges the word shown on q_o.
REQ-008 SHALL have port q_o  output  DWIDTH  head-of-queue data (show-ahead).
REQ-009 SHALL have port empty_o  output  1  high when q_o holds no valid word.
REQ-010 SHALL have port full_o  output  1  high when usedw_o == DEPTH.
REQ-011 SHALL have port usedw_o  output  AWIDTH+1  count of accepted, not-yet-popped words.

Function
REQ-012 Write accepted iff wrreq_i=1 and full_o=0 at the edge; data_i stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-013 Write with full_o=1 SHALL be ignored regardless of rdreq_i; no state change from it.
REQ-014 Pop accepted iff rdreq_i=1 and empty_o=0; rdreq_i with empty_o=1 SHALL be ignored.
REQ-015 Show-ahead: whenever empty_o=0, q_o SHALL equal the oldest unpopped word; q_o holds stable until popped.
REQ-016 Storage read latency is one cycle; the storage output register is q_o; a prefetch is issued at an edge when storage holds unread words and (output slot empty or pop accepted at that edge).
REQ-017 Prefetch increments rd_ptr modulo DEPTH; output-valid flag set on prefetch, cleared on pop without prefetch.
REQ-018 empty_o = not output-valid; write at edge N into empty FIFO SHALL give empty_o=0 and q_o=data after edge N+1.
REQ-019 Sustained pops SHALL run at one word per cycle while storage holds unread words.
REQ-020 usedw_o SHALL increment on accepted write alone, decrement on accepted pop alone, hold when both or neither; usedw_o may be nonzero while empty_o=1 (one cycle after a write to empty).
REQ-021 full_o registered, equal to (usedw_o == DEPTH); total occupancy including output slot SHALL never exceed DEPTH.
REQ-022 Simultaneous accepted write and pop when full_o=0: both take effect, usedw_o unchanged.
REQ-023 Pointers wrap from DEPTH-1 to 0 without loss or reordering.

Reset
REQ-024 srst_ni=0 at an edge SHALL set wr_ptr=0, rd_ptr=0, output-valid=0, usedw_o=0, empty_o=1, full_o=0; q_o contents are not reset and are don't-care while empty_o=1.
REQ-025 Reset mid-operation SHALL discard all stored words and any in-flight prefetch; wrreq_i/rdreq_i during reset ignored.

Structure
REQ-026 Storage SHALL be one instance of sub-module sc_ram (REGISTER_OUTPUT=0, DWIDTH, AWIDTH passed through), its rd_en driven by the prefetch condition.
REQ-027 No shared package; DEPTH is a localparam derived from AWIDTH.

Verification (DWIDTH=8, AWIDTH=2, DEPTH=4)
REQ-028 Reset, then write 0x11 at edge N -> usedw_o=1 after N; empty_o=0, q_o=0x11 after N+1.
REQ-029 Write 0x01..0x04 back-to-back -> full_o=1, usedw_o=4; fifth write 0x05 ignored; four pops return 0x01..0x04 on consecutive cycles, then empty_o=1, usedw_o=0.
REQ-030 Full FIFO, wrreq_i=1 and rdreq_i=1 same edge -> pop accepted, write dropped, usedw_o=3, full_o=0.
REQ-031 usedw_o=2, simultaneous write 0xAA and pop -> usedw_o stays 2; 0xAA emerges in order; 10 write/pop cycles wrap pointers with no reorder.
REQ-032 rdreq_i=1 on empty FIFO -> no change, usedw_o stays 0; srst_ni=0 with usedw_o=3 -> next cycle empty_o=1, usedw_o=0, subsequent write 0x5A read back first.
